gf180mcu_ef_io__bi_ctrl: RTL and testbench
==========================================

Name: gf180mcu_ef_io__bi_ctrl

Overview:
- Per-pad digital controller placed directly upstream of the bidirectional pad cell.
- Drives every pad control pin: CS, SL, IE, OE, PU, PD, A, PDRV0 and PDRV1.
- Consumes the pad's Y output and delivers a synchronised, debounced input with edge interrupts to the core.
- Sequences direction changes through a turnaround state, so OE and IE are never both asserted.

Parameters:
- TURN_CYC, 4, cycles spent in TURN (both OE and IE low) on every direction change; must be ≥1.
- DEB_CYC, 8, consecutive stable cycles required before DIN updates; must be ≥1.
- DEB_W, 4, width of the debounce counter; requires 2^DEB_W > DEB_CYC.

Ports:
- CLK  in  1  single block clock.
- RESET_N  in  1  asynchronous, active-low reset.
- CFG_WE  in  1  config write strobe.
- CFG_WDATA  in  8  config word:
  - [0] DIR (1 = output)
  - [1] PU
  - [2] PD
  - [3] SL
  - [4] CS
  - [6:5] PDRV
  - [7] IE_EN
- DOUT  in  1  output data.
- IRQ_MODE  in  2  edge select: 00 off, 01 rise, 10 fall, 11 both.
- IRQ_CLR  in  1  clears IRQ.
- PAD_Y  in  1  from pad Y.
- PAD_CS, PAD_SL, PAD_IE, PAD_OE, PAD_PU, PAD_PD, PAD_A, PAD_PDRV0, PAD_PDRV1  out  1 each  to pad.
- DIN  out  1  filtered input.
- IRQ  out  1  sticky edge flag.
- DIR_BUSY  out  1  high while in TURN.

Behaviour:
- Reset:
  - Config register = 0x00; FSM = IN.
  - All PAD_* outputs = 0, DIN = 0, IRQ = 0, DIR_BUSY = 0, debounce counter = 0, sync flops = 0.
  - Net result: pad tristate with input buffer off.
- Config write:
  - Register loads at the CLK edge when CFG_WE = 1.
  - PAD_SL, PAD_CS and PAD_PDRV* are registered and follow the config one cycle after the write.
- FSM states: IN, TURN, OUT.
  - IN: PAD_OE = 0; PAD_IE = IE_EN.
  - OUT: PAD_OE = 1; PAD_IE = 0; PAD_A = registered DOUT (1-cycle latency).
  - TURN: PAD_OE = 0; PAD_IE = 0; PAD_A = 0; DIR_BUSY = 1; lasts exactly TURN_CYC cycles.
  - Transitions: IN with DIR = 1 → TURN. OUT with DIR = 0 → TURN. TURN exit → OUT if DIR = 1, else IN.
  - DIR is re-sampled only at TURN exit. Toggling DIR during TURN never shortens or restarts TURN.
- PAD_A:
  - Forced to 0 outside OUT.
  - A DOUT change in OUT appears on PAD_A at the next edge.
- Pull control:
  - PAD_PU = PU & ~PD, and PAD_PD = PD & ~PU, both only in IN; both are 0 in TURN and OUT.
  - PU = PD = 1 results in no pull.
- Input path:
  - PAD_Y passes through a 2-flop synchroniser.
  - The debounce counter resets whenever the sync output equals DIN, or whenever PAD_IE = 0.
  - Otherwise the counter increments. When it reaches DEB_CYC − 1 with the sync output still different from DIN, DIN takes the sync value at that edge and the counter clears.
  - Latency: a stable PAD_Y change appears on DIN 2 + DEB_CYC edges after it is first sampled.
  - A glitch shorter than DEB_CYC cycles never reaches DIN.
- While PAD_IE = 0:
  - DIN holds its last value.
  - No edges are generated.
- IRQ:
  - Set one cycle after a DIN transition that matches IRQ_MODE.
  - Stays set until IRQ_CLR.
  - If set and clear occur in the same cycle, set wins.
  - IRQ_MODE = 00 never sets IRQ and does not clear it.
- Reset asserted mid-TURN or mid-debounce: all state returns immediately (asynchronously) to reset values.

Optional Feature:
- Macro: GF180MCU_EF_IO_DEBOUNCE_EN.
- Defined: the debounce counter and DEB_CYC behaviour above are present.
- Undefined: the counter is not built; DIN = second sync flop, gated by PAD_IE (holds while PAD_IE = 0); latency is 2 edges; DEB_CYC and DEB_W are ignored.

Decomposition:
- Package gf180mcu_ef_io_pkg holds:
  - CFG_WDATA bit-index constants (CFG_DIR, CFG_PU, CFG_PD, CFG_SL, CFG_CS, CFG_PDRV_LO/HI, CFG_IE_EN);
  - the FSM state enum (ST_IN, ST_TURN, ST_OUT);
  - the IRQ_MODE encodings.
- Sub-module gf180mcu_ef_io__in_filt contains the synchroniser, the debounce logic and the edge detector. It has inputs CLK, RESET_N, PAD_Y, IE and outputs DIN, RISE, FALL.
- The top level holds the config register, FSM, pad drive logic and IRQ.

Test Plan:
- Reset, then write CFG_WDATA = 0x80 → after 1 cycle PAD_IE = 1, PAD_OE = 0. Drive PAD_Y 0→1 → DIN = 1 exactly 10 edges later (2 + 8).
- From IN, write 0x01 → DIR_BUSY = 1 and PAD_OE = PAD_IE = 0 for exactly 4 cycles, then PAD_OE = 1. Toggle DOUT → PAD_A follows after 1 cycle. PAD_OE & PAD_IE is never 1 at any cycle.
- During TURN, write DIR back to 0 → TURN still lasts 4 cycles, then the FSM returns to IN with PAD_OE never asserted.
- IE_EN = 1, IRQ_MODE = 01, PAD_Y pulse of 5 cycles → DIN and IRQ unchanged. Pulse of 12 cycles → DIN rises, IRQ = 1. Assert IRQ_CLR in the same cycle as a new rise → IRQ stays 1.
- Write 0x06 (PU = PD = 1, input) → PAD_PU = PAD_PD = 0. Write 0x02 → PAD_PU = 1. Write 0x03 → after TURN, PAD_PU = 0.
- Assert RESET_N low mid-TURN and mid-debounce → all outputs 0 immediately. After release, FSM = IN and DIN = 0. Repeat without GF180MCU_EF_IO_DEBOUNCE_EN → latency 2 edges and 1-cycle glitches pass to DIN.

Source files
------------

// File: rtl/gf180mcu_ef_io_pkg.sv
// gf180mcu_ef_io_pkg
// Shared definitions for the bidirectional pad controller:
//   - bit positions inside the CFG_WDATA configuration word
//   - direction FSM state encoding
//   - IRQ_MODE edge-select encodings
package gf180mcu_ef_io_pkg;

    // CFG_WDATA bit positions
    localparam int unsigned CFG_DIR     = 0;
    localparam int unsigned CFG_PU      = 1;
    localparam int unsigned CFG_PD      = 2;
    localparam int unsigned CFG_SL      = 3;
    localparam int unsigned CFG_CS      = 4;
    localparam int unsigned CFG_PDRV_LO = 5;
    localparam int unsigned CFG_PDRV_HI = 6;
    localparam int unsigned CFG_IE_EN   = 7;

    // Direction sequencing FSM
    typedef enum logic [1:0] {
        ST_IN   = 2'd0,
        ST_TURN = 2'd1,
        ST_OUT  = 2'd2
    } dir_state_e;

    // IRQ_MODE encodings
    typedef enum logic [1:0] {
        IRQ_OFF  = 2'b00,
        IRQ_RISE = 2'b01,
        IRQ_FALL = 2'b10,
        IRQ_BOTH = 2'b11
    } irq_mode_e;

endpackage

// File: rtl/gf180mcu_ef_io__in_filt.sv
// gf180mcu_ef_io__in_filt
// Input path for the pad controller: 2-flop synchroniser on PAD_Y, optional
// debounce filter, and edge detector on the filtered value.
//
// Optional feature macro: GF180MCU_EF_IO_DEBOUNCE_EN
//   defined   : DIN only follows the synchronised input after it has differed
//               from DIN for DEB_CYC consecutive cycles.
//   undefined : DIN is the second sync flop itself (held while IE = 0).
//
// Ports:
//   CLK, RESET_N : clock, asynchronous active-low reset
//   PAD_Y        : raw pad input
//   IE           : pad input buffer enable; DIN holds and no edges while low
//   DIN          : filtered input
//   RISE, FALL   : single-cycle pulses in the cycle after DIN changes
module gf180mcu_ef_io__in_filt #(
    parameter int unsigned DEB_CYC = 8,
    parameter int unsigned DEB_W   = 4
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic PAD_Y,
    input  logic IE,
    output logic DIN,
    output logic RISE,
    output logic FALL
);

    logic sync1_q;
    logic sync1_d;
    logic sync2_q;
    logic sync2_d;
    logic din_prev_q;
    logic din_prev_d;
    logic din_cur;

    assign sync1_d = PAD_Y;

`ifdef GF180MCU_EF_IO_DEBOUNCE_EN
    logic             din_q;
    logic             din_d;
    logic [DEB_W-1:0] cnt_q;
    logic [DEB_W-1:0] cnt_d;

    assign sync2_d = sync1_q;

    // Counter runs only while the synchronised value disagrees with DIN;
    // any agreement (or IE low) restarts the stability window.
    always_comb begin
        din_d = din_q;
        cnt_d = cnt_q;
        if (!IE || (sync2_q == din_q)) begin
            cnt_d = '0;
        end else if (cnt_q == DEB_W'(DEB_CYC - 1)) begin
            din_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            din_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            din_q <= din_d;
            cnt_q <= cnt_d;
        end
    end

    assign din_cur = din_q;
`else
    localparam int unsigned deb_params_unused = DEB_CYC + DEB_W;

    // Second sync flop doubles as DIN; it freezes while the input buffer is off.
    assign sync2_d = IE ? sync1_q : sync2_q;
    assign din_cur = sync2_q;
`endif

    assign din_prev_d = din_cur;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            din_prev_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            din_prev_q <= din_prev_d;
        end
    end

    assign DIN  = din_cur;
    assign RISE = IE &  din_cur & ~din_prev_q;
    assign FALL = IE & ~din_cur &  din_prev_q;

endmodule

// File: rtl/gf180mcu_ef_io__bi_ctrl.sv
// gf180mcu_ef_io__bi_ctrl
// Per-pad controller for the gf180mcu bidirectional pad cell. Holds the pad
// configuration register, sequences direction changes through a TURN state
// (OE and IE both low) and produces a filtered input with a sticky edge IRQ.
//
// Optional feature macro: GF180MCU_EF_IO_DEBOUNCE_EN (selects the debounce
// filter inside gf180mcu_ef_io__in_filt).
//
// Ports:
//   CLK, RESET_N          : clock, asynchronous active-low reset
//   CFG_WE, CFG_WDATA[7:0]: config write ({IE_EN, PDRV[1:0], CS, SL, PD, PU, DIR})
//   DOUT                  : output data, registered onto PAD_A in OUT
//   IRQ_MODE[1:0], IRQ_CLR: edge select (off/rise/fall/both) and IRQ clear
//   PAD_Y                 : pad input
//   PAD_*                 : pad control pins
//   DIN, IRQ, DIR_BUSY    : filtered input, sticky edge flag, TURN indicator
module gf180mcu_ef_io__bi_ctrl
    import gf180mcu_ef_io_pkg::*;
#(
    parameter int unsigned TURN_CYC = 4,
    parameter int unsigned DEB_CYC  = 8,
    parameter int unsigned DEB_W    = 4
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       CFG_WE,
    input  logic [7:0] CFG_WDATA,
    input  logic       DOUT,
    input  logic [1:0] IRQ_MODE,
    input  logic       IRQ_CLR,
    input  logic       PAD_Y,
    output logic       PAD_CS,
    output logic       PAD_SL,
    output logic       PAD_IE,
    output logic       PAD_OE,
    output logic       PAD_PU,
    output logic       PAD_PD,
    output logic       PAD_A,
    output logic       PAD_PDRV0,
    output logic       PAD_PDRV1,
    output logic       DIN,
    output logic       IRQ,
    output logic       DIR_BUSY
);

    localparam int unsigned TURN_W = $clog2(TURN_CYC + 1);

    logic [7:0]        cfg_q;
    logic [7:0]        cfg_d;
    dir_state_e        state_q;
    dir_state_e        state_d;
    logic [TURN_W-1:0] turn_cnt_q;
    logic [TURN_W-1:0] turn_cnt_d;
    logic              dout_q;
    logic              dout_d;
    logic              irq_q;
    logic              irq_d;
    logic              irq_set;
    logic              rise;
    logic              fall;

    // Config register and registered output data
    always_comb begin
        cfg_d  = CFG_WE ? CFG_WDATA : cfg_q;
        dout_d = DOUT;
    end

    // FSM: state register
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cfg_q      <= '0;
            dout_q     <= 1'b0;
            state_q    <= ST_IN;
            turn_cnt_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            cfg_q      <= cfg_d;
            dout_q     <= dout_d;
            state_q    <= state_d;
            turn_cnt_q <= turn_cnt_d;
            irq_q      <= irq_d;
        end
    end

    // FSM: next state. DIR is only looked at again when TURN completes, so
    // rewriting it mid-turnaround cannot shorten or restart the turn.
    always_comb begin
        state_d    = state_q;
        turn_cnt_d = '0;
        unique case (state_q)
            ST_IN: begin
                if (cfg_q[CFG_DIR]) state_d = ST_TURN;
            end
            ST_OUT: begin
                if (!cfg_q[CFG_DIR]) state_d = ST_TURN;
            end
            ST_TURN: begin
                if (turn_cnt_q == TURN_W'(TURN_CYC - 1)) begin
                    state_d = cfg_q[CFG_DIR] ? ST_OUT : ST_IN;
                end else begin
                    turn_cnt_d = turn_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IN;
        endcase
    end

    // FSM: outputs. OE and IE come from disjoint states, so never overlap.
    always_comb begin
        PAD_OE   = 1'b0;
        PAD_IE   = 1'b0;
        PAD_A    = 1'b0;
        PAD_PU   = 1'b0;
        PAD_PD   = 1'b0;
        DIR_BUSY = 1'b0;
        unique case (state_q)
            ST_IN: begin
                PAD_IE = cfg_q[CFG_IE_EN];
                PAD_PU = cfg_q[CFG_PU] & ~cfg_q[CFG_PD];
                PAD_PD = cfg_q[CFG_PD] & ~cfg_q[CFG_PU];
            end
            ST_OUT: begin
                PAD_OE = 1'b1;
                PAD_A  = dout_q;
            end
            ST_TURN: begin
                DIR_BUSY = 1'b1;
            end
            default: ;
        endcase
    end

    assign PAD_SL    = cfg_q[CFG_SL];
    assign PAD_CS    = cfg_q[CFG_CS];
    assign PAD_PDRV0 = cfg_q[CFG_PDRV_LO];
    assign PAD_PDRV1 = cfg_q[CFG_PDRV_HI];

    gf180mcu_ef_io__in_filt #(
        .DEB_CYC (DEB_CYC),
        .DEB_W   (DEB_W)
    ) u_in_filt (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .PAD_Y   (PAD_Y),
        .IE      (PAD_IE),
        .DIN     (DIN),
        .RISE    (rise),
        .FALL    (fall)
    );

    // Sticky IRQ; a set in the same cycle as a clear takes priority.
    always_comb begin
        irq_set = 1'b0;
        unique case (IRQ_MODE)
            IRQ_RISE: irq_set = rise;
            IRQ_FALL: irq_set = fall;
            IRQ_BOTH: irq_set = rise | fall;
            default:  irq_set = 1'b0;
        endcase
        irq_d = irq_q;
        if (IRQ_CLR) irq_d = 1'b0;
        if (irq_set) irq_d = 1'b1;
    end

    assign IRQ = irq_q;

endmodule

// File: tb/tb_gf180mcu_ef_io__bi_ctrl.sv
// Directed testbench for gf180mcu_ef_io__bi_ctrl. Expected values are hand
// derived; the input-path latency depends on GF180MCU_EF_IO_DEBOUNCE_EN.
module tb_gf180mcu_ef_io__bi_ctrl;

    localparam int unsigned TURN = 4;
`ifdef GF180MCU_EF_IO_DEBOUNCE_EN
    localparam bit DEB = 1'b1;
    localparam int LAT = 10;
`else
    localparam bit DEB = 1'b0;
    localparam int LAT = 2;
`endif
    localparam int GLITCH_W = DEB ? 5 : 1;
    localparam int PRE_RST  = DEB ? 4 : 1;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       CFG_WE;
    logic [7:0] CFG_WDATA;
    logic       DOUT;
    logic [1:0] IRQ_MODE;
    logic       IRQ_CLR;
    logic       PAD_Y;
    logic       PAD_CS, PAD_SL, PAD_IE, PAD_OE, PAD_PU, PAD_PD, PAD_A;
    logic       PAD_PDRV0, PAD_PDRV1, DIN, IRQ, DIR_BUSY;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned ovl_cnt = 0;
    int unsigned oe_cnt = 0;

    gf180mcu_ef_io__bi_ctrl #(
        .TURN_CYC (TURN),
        .DEB_CYC  (8),
        .DEB_W    (4)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .CFG_WE    (CFG_WE),
        .CFG_WDATA (CFG_WDATA),
        .DOUT      (DOUT),
        .IRQ_MODE  (IRQ_MODE),
        .IRQ_CLR   (IRQ_CLR),
        .PAD_Y     (PAD_Y),
        .PAD_CS    (PAD_CS),
        .PAD_SL    (PAD_SL),
        .PAD_IE    (PAD_IE),
        .PAD_OE    (PAD_OE),
        .PAD_PU    (PAD_PU),
        .PAD_PD    (PAD_PD),
        .PAD_A     (PAD_A),
        .PAD_PDRV0 (PAD_PDRV0),
        .PAD_PDRV1 (PAD_PDRV1),
        .DIN       (DIN),
        .IRQ       (IRQ),
        .DIR_BUSY  (DIR_BUSY)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (PAD_OE && PAD_IE) ovl_cnt++;
        if (PAD_OE) oe_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic cfg_write(input logic [7:0] v);
        CFG_WDATA = v;
        CFG_WE    = 1'b1;
        step(1);
        CFG_WE    = 1'b0;
    endtask

    task automatic irq_clear();
        IRQ_CLR = 1'b1;
        step(1);
        IRQ_CLR = 1'b0;
    endtask

    function automatic logic [11:0] outs();
        return {PAD_CS, PAD_SL, PAD_IE, PAD_OE, PAD_PU, PAD_PD, PAD_A,
                PAD_PDRV0, PAD_PDRV1, DIN, IRQ, DIR_BUSY};
    endfunction

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int unsigned oe0;
        logic din_seen;

        RESET_N = 1'b0; CFG_WE = 1'b0; CFG_WDATA = '0; DOUT = 1'b0;
        IRQ_MODE = 2'b00; IRQ_CLR = 1'b0; PAD_Y = 1'b0;
        step(3);
        chk("reset_outs", outs(), 0);
        RESET_N = 1'b1;
        step(1);
        chk("post_reset_outs", outs(), 0);

        // Input enable and input latency
        cfg_write(8'h80);
        chk("ie_on", PAD_IE, 1);
        chk("oe_off_in", PAD_OE, 0);
        PAD_Y = 1'b1;
        n = 0;
        while (DIN !== 1'b1 && n < 40) begin step(1); n++; end
        chk("din_latency", n, LAT);
        PAD_Y = 1'b0;
        step(LAT + 2);
        chk("din_fall", DIN, 0);
        chk("irq_mode_off", IRQ, 0);

        // IN -> TURN -> OUT
        cfg_write(8'h81);
        chk("dir_still_in", {PAD_IE, DIR_BUSY}, 2'b10);
        step(1);
        chk("turn_oe_ie", {PAD_OE, PAD_IE, DIR_BUSY}, 3'b001);
        n = 0;
        while (DIR_BUSY && n < 20) begin n++; step(1); end
        chk("turn_len", n, TURN);
        chk("out_oe_ie", {PAD_OE, PAD_IE}, 2'b10);
        DOUT = 1'b1;
        chk("pad_a_before", PAD_A, 0);
        step(1);
        chk("pad_a_rise", PAD_A, 1);
        DOUT = 1'b0;
        step(1);
        chk("pad_a_fall", PAD_A, 0);
        DOUT = 1'b1;
        step(1);

        // OUT -> TURN -> IN with DOUT held high
        cfg_write(8'h80);
        step(1);
        chk("turn_pad_a", {PAD_A, DIR_BUSY}, 2'b01);
        step(TURN);
        chk("back_in", {PAD_OE, PAD_IE, DIR_BUSY, PAD_A}, 4'b0100);

        // DIR toggled back during TURN: full-length turn, OE never asserted
        oe0 = oe_cnt;
        cfg_write(8'h81);
        step(1);
        chk("abort_busy", DIR_BUSY, 1);
        cfg_write(8'h80);
        n = 1;
        while (DIR_BUSY && n < 20) begin n++; step(1); end
        chk("turn_len_abort", n, TURN);
        chk("abort_in", {PAD_OE, PAD_IE, DIR_BUSY}, 3'b010);
        chk("abort_no_oe", oe_cnt - oe0, 0);

        // Glitch rejection (debounce) or pass-through (no debounce)
        IRQ_MODE = 2'b01;
        din_seen = 1'b0;
        PAD_Y = 1'b1;
        for (int i = 0; i < GLITCH_W + LAT + 4; i++) begin
            if (i == GLITCH_W) PAD_Y = 1'b0;
            step(1);
            din_seen |= DIN;
        end
        chk("glitch_din", din_seen, DEB ? 0 : 1);
        chk("glitch_irq", IRQ, DEB ? 0 : 1);
        irq_clear();
        chk("irq_clr", IRQ, 0);

        PAD_Y = 1'b1;
        step(12);
        chk("long_din", DIN, 1);
        chk("long_irq", IRQ, 1);
        IRQ_MODE = 2'b00;
        PAD_Y = 1'b0;
        step(LAT + 3);
        chk("mode0_hold_irq", IRQ, 1);
        chk("mode0_din_low", DIN, 0);

        // Falling-edge mode
        IRQ_MODE = 2'b10;
        irq_clear();
        chk("fall_clr", IRQ, 0);
        PAD_Y = 1'b1;
        step(LAT + 3);
        chk("fall_mode_rise_ignored", IRQ, 0);
        PAD_Y = 1'b0;
        step(LAT + 3);
        chk("fall_irq", IRQ, 1);

        // Set beats clear in the same cycle
        IRQ_MODE = 2'b01;
        irq_clear();
        chk("pre_set_wins", IRQ, 0);
        PAD_Y = 1'b1;
        n = 0;
        while (DIN !== 1'b1 && n < 40) begin step(1); n++; end
        chk("din_latency_2", n, LAT);
        IRQ_CLR = 1'b1;
        step(1);
        IRQ_CLR = 1'b0;
        chk("set_wins", IRQ, 1);
        irq_clear();
        chk("clr_after_set", IRQ, 0);

        // Pull control
        IRQ_MODE = 2'b00;
        PAD_Y = 1'b0;
        cfg_write(8'h06);
        chk("pull_both", {PAD_PU, PAD_PD}, 2'b00);
        cfg_write(8'h02);
        chk("pull_up", {PAD_PU, PAD_PD}, 2'b10);
        cfg_write(8'h04);
        chk("pull_down", {PAD_PU, PAD_PD}, 2'b01);
        cfg_write(8'h03);
        chk("pull_up_pre_turn", {PAD_PU, PAD_PD}, 2'b10);
        step(1);
        chk("pull_turn", {PAD_PU, PAD_PD, DIR_BUSY}, 3'b001);
        step(TURN);
        chk("pull_out", {PAD_PU, PAD_PD, PAD_OE}, 3'b001);

        // Registered drive controls
        cfg_write(8'h29);
        chk("drive_bits_a", {PAD_CS, PAD_SL, PAD_PDRV1, PAD_PDRV0}, 4'b0101);
        cfg_write(8'h50);
        chk("drive_bits_b", {PAD_CS, PAD_SL, PAD_PDRV1, PAD_PDRV0}, 4'b1010);

        // Reset in the middle of TURN
        step(1);
        chk("pre_rst_turn", DIR_BUSY, 1);
        RESET_N = 1'b0;
        #1;
        chk("rst_mid_turn", outs(), 0);
        step(2);
        RESET_N = 1'b1;
        step(1);
        chk("rst_turn_release", outs(), 0);

        // Reset in the middle of a debounce window with DIN and IRQ high
        cfg_write(8'h80);
        IRQ_MODE = 2'b01;
        PAD_Y = 1'b1;
        step(LAT + 3);
        chk("pre_rst_din_irq", {DIN, IRQ}, 2'b11);
        PAD_Y = 1'b0;
        step(PRE_RST);
        chk("pre_rst_din_held", DIN, 1);
        RESET_N = 1'b0;
        #1;
        chk("rst_mid_deb", outs(), 0);
        step(2);
        RESET_N = 1'b1;
        step(1);
        chk("rst_deb_release", outs(), 0);

        chk("no_oe_ie_overlap", ovl_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
